// File: rtl/uff_pkg.sv
// rtl/uff_pkg.sv - mode encoding and default sizes for the universal flip-flop bank
package uff_pkg;

  typedef enum logic [1:0] {
    MODE_D  = 2'd0,
    MODE_T  = 2'd1,
    MODE_JK = 2'd2,
    MODE_SR = 2'd3
  } uff_mode_e;

  localparam int UFF_WIDTH_DEF = 8;
  localparam int UFF_CNT_W_DEF = 8;

endpackage

// File: rtl/univ_ff_bank_if.sv
// rtl/univ_ff_bank_if.sv - control/data bundle of the flip-flop bank
// err_cnt is present only when UFF_ERR_CNT_EN is defined.
interface univ_ff_bank_if #(
  parameter int WIDTH = uff_pkg::UFF_WIDTH_DEF,
  parameter int CNT_W = uff_pkg::UFF_CNT_W_DEF
);
  logic              en;
  logic              clr;
  uff_pkg::uff_mode_e mode;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic              err_clr;
  logic [WIDTH-1:0]  q;
  logic [WIDTH-1:0]  qn;
  logic              sr_err;
`ifdef UFF_ERR_CNT_EN
  logic [CNT_W-1:0]  err_cnt;
`endif

  modport master (
    output en, clr, mode, a, b, err_clr,
    input  q, qn, sr_err
`ifdef UFF_ERR_CNT_EN
    , err_cnt
`endif
  );

  modport slave (
    input  en, clr, mode, a, b, err_clr,
    output q, qn, sr_err
`ifdef UFF_ERR_CNT_EN
    , err_cnt
`endif
  );
endinterface

// File: rtl/uff_cell.sv
// rtl/uff_cell.sv - next-state of one bank bit plus its illegal-SR flag
module uff_cell
  import uff_pkg::*;
(
  input  uff_mode_e mode,
  input  logic      a,
  input  logic      b,
  input  logic      q,
  output logic      nxt,
  output logic      illegal
);

  always_comb begin
    nxt = q;
    unique case (mode)
      MODE_D:  nxt = a;
      MODE_T:  nxt = q ^ a;
      MODE_JK: begin
        unique case ({a, b})
          2'b00:   nxt = q;
          2'b01:   nxt = 1'b0;
          2'b10:   nxt = 1'b1;
          default: nxt = ~q;
        endcase
      end
      default: begin
        // S=R=1 holds so the bit stays deterministic
        unique case ({a, b})
          2'b01:   nxt = 1'b0;
          2'b10:   nxt = 1'b1;
          default: nxt = q;
        endcase
      end
    endcase
  end

  assign illegal = (mode == MODE_SR) && a && b;

endmodule

// File: rtl/univ_ff_bank.sv
// rtl/univ_ff_bank.sv - WIDTH-bit D/T/JK/SR flip-flop bank with sticky illegal-SR flag
// Define UFF_ERR_CNT_EN to add the saturating illegal-SR cycle counter err_cnt.
module univ_ff_bank
  import uff_pkg::*;
#(
  parameter int WIDTH = UFF_WIDTH_DEF,
  parameter int CNT_W = UFF_CNT_W_DEF
) (
  input logic             clk,
  input logic             rst,
  univ_ff_bank_if.slave   bus
);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] ill_bits;
  logic             illegal_ev;
  logic             sr_err_r;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    uff_cell u_cell (
      .mode    (bus.mode),
      .a       (bus.a[i]),
      .b       (bus.b[i]),
      .q       (q_r[i]),
      .nxt     (nxt[i]),
      .illegal (ill_bits[i])
    );
  end

  // clr outranks en, so a cleared cycle never counts as an illegal event
  assign illegal_ev = bus.en && !bus.clr && (|ill_bits);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          q_r <= '0;
    else if (bus.clr) q_r <= '0;
    else if (bus.en)  q_r <= nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              sr_err_r <= 1'b0;
    else if (illegal_ev)  sr_err_r <= 1'b1;
    else if (bus.err_clr) sr_err_r <= 1'b0;
  end

  assign bus.q      = q_r;
  assign bus.qn     = ~q_r;
  assign bus.sr_err = sr_err_r;

`ifdef UFF_ERR_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic [CNT_W-1:0] cnt_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                cnt_r <= '0;
    else if (bus.err_clr)                   cnt_r <= illegal_ev ? CNT_W'(1) : '0;
    else if (illegal_ev && cnt_r != CNT_MAX) cnt_r <= cnt_r + 1'b1;
  end

  assign bus.err_cnt = cnt_r;
`endif

endmodule

// File: tb/tb_univ_ff_bank.sv
// tb/tb_univ_ff_bank.sv - directed self-checking bench for univ_ff_bank
module tb_univ_ff_bank;
  import uff_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  univ_ff_bank_if #(.WIDTH(8), .CNT_W(8)) bus ();

  univ_ff_bank #(.WIDTH(8), .CNT_W(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef UFF_ERR_CNT_EN
  univ_ff_bank_if #(.WIDTH(8), .CNT_W(2)) bus_sat ();

  assign bus_sat.en      = bus.en;
  assign bus_sat.clr     = bus.clr;
  assign bus_sat.mode    = bus.mode;
  assign bus_sat.a       = bus.a;
  assign bus_sat.b       = bus.b;
  assign bus_sat.err_clr = bus.err_clr;

  univ_ff_bank #(.WIDTH(8), .CNT_W(2)) u_dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus_sat)
  );
`endif

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cnt_chk(input string tag, input int exp_main, input int exp_sat);
`ifdef UFF_ERR_CNT_EN
    chk({tag, "_cnt"}, 64'(bus.err_cnt), 64'(exp_main));
    chk({tag, "_cnt_sat"}, 64'(bus_sat.err_cnt), 64'(exp_sat));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input uff_mode_e m, input logic e, input logic c,
                       input logic [7:0] av, input logic [7:0] bv, input logic ec);
    bus.mode    = m;
    bus.en      = e;
    bus.clr     = c;
    bus.a       = av;
    bus.b       = bv;
    bus.err_clr = ec;
  endtask

  initial begin
    drive(MODE_D, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    #3;
    chk("rst_q", 64'(bus.q), 64'h00);
    chk("rst_qn", 64'(bus.qn), 64'hFF);
    chk("rst_sr_err", 64'(bus.sr_err), 64'h0);
    cnt_chk("rst", 0, 0);
    tick();
    tick();
    rst = 1'b0;

    // D mode: clr wins over en, then the data loads
    drive(MODE_D, 1'b1, 1'b1, 8'hA5, 8'h00, 1'b0);
    tick();
    chk("d_clr", 64'(bus.q), 64'h00);
    bus.clr = 1'b0;
    tick();
    chk("d_load", 64'(bus.q), 64'hA5);
    chk("d_qn", 64'(bus.qn), 64'h5A);
    drive(MODE_D, 1'b0, 1'b0, 8'h3C, 8'h00, 1'b0);
    tick();
    chk("d_hold", 64'(bus.q), 64'hA5);

    // asynchronous reset between edges
    rst = 1'b1;
    #1;
    chk("async_rst_q", 64'(bus.q), 64'h00);
    chk("async_rst_qn", 64'(bus.qn), 64'hFF);
    rst = 1'b0;

    // JK mode
    drive(MODE_D, 1'b1, 1'b0, 8'h0F, 8'h00, 1'b0);
    tick();
    chk("jk_pre", 64'(bus.q), 64'h0F);
    drive(MODE_JK, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b0);
    tick();
    chk("jk_tog1", 64'(bus.q), 64'hF0);
    tick();
    chk("jk_tog2", 64'(bus.q), 64'h0F);
    drive(MODE_JK, 1'b1, 1'b0, 8'h33, 8'h55, 1'b0);
    tick();
    chk("jk_mix", 64'(bus.q), 64'h3A);

    // T mode: en=0 holds across many edges
    drive(MODE_T, 1'b0, 1'b0, 8'hFF, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    chk("t_hold", 64'(bus.q), 64'h3A);
    drive(MODE_T, 1'b1, 1'b0, 8'h0F, 8'h00, 1'b0);
    tick();
    chk("t_tog", 64'(bus.q), 64'h35);
    drive(MODE_T, 1'b1, 1'b1, 8'hFF, 8'h00, 1'b0);
    tick();
    chk("t_clr", 64'(bus.q), 64'h00);
    chk("pre_sr_err", 64'(bus.sr_err), 64'h0);

    // SR mode with an illegal bit alongside a legal one
    drive(MODE_SR, 1'b1, 1'b0, 8'h81, 8'h01, 1'b0);
    tick();
    chk("sr_q", 64'(bus.q), 64'h80);
    chk("sr_err1", 64'(bus.sr_err), 64'h1);
    cnt_chk("sr1", 1, 1);
    for (int i = 0; i < 3; i++) tick();
    chk("sr_q4", 64'(bus.q), 64'h80);
    cnt_chk("sr4", 4, 3);
    tick();
    cnt_chk("sr5", 5, 3);

    // legal SR cycle keeps the sticky flag and the count
    drive(MODE_SR, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    tick();
    chk("sr_sticky", 64'(bus.sr_err), 64'h1);
    cnt_chk("sr_sticky", 5, 3);

    // err_clr together with an illegal event: set wins, count reloads to 1
    drive(MODE_SR, 1'b1, 1'b0, 8'h01, 8'h01, 1'b1);
    tick();
    chk("clr_set_err", 64'(bus.sr_err), 64'h1);
    cnt_chk("clr_set", 1, 1);

    // err_clr alone, with a legal set/reset pattern
    drive(MODE_SR, 1'b1, 1'b0, 8'h02, 8'h80, 1'b1);
    tick();
    chk("errclr_q", 64'(bus.q), 64'h02);
    chk("errclr_err", 64'(bus.sr_err), 64'h0);
    cnt_chk("errclr", 0, 0);

    // illegal pattern masked by clr or by en=0
    drive(MODE_SR, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b0);
    tick();
    chk("clr_ill_q", 64'(bus.q), 64'h00);
    chk("clr_ill_err", 64'(bus.sr_err), 64'h0);
    bus.clr = 1'b0;
    bus.en  = 1'b0;
    tick();
    chk("en0_ill_err", 64'(bus.sr_err), 64'h0);
    cnt_chk("masked", 0, 0);

    // reset mid toggle sequence discards state
    drive(MODE_T, 1'b1, 1'b0, 8'h5A, 8'h00, 1'b0);
    tick();
    chk("tog_pre", 64'(bus.q), 64'h5A);
    rst = 1'b1;
    #1;
    chk("tog_rst", 64'(bus.q), 64'h00);
    tick();
    chk("rst_held", 64'(bus.q), 64'h00);
    rst = 1'b0;
    tick();
    chk("post_rst_tog", 64'(bus.q), 64'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/univ_ff_bank.md
UNIV_FF_BANK -- requirements
Module: univ_ff_bank

Interface
REQ-001 Parameter WIDTH, 8, number of flip-flop bits in the bank (1..64).
REQ-002 Parameter CNT_W, 8, width of the illegal-SR event counter.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port en  input  1  bank update enable; 0 = all bits hold.
REQ-006 Port clr  input  1  synchronous clear of q.
REQ-007 Port mode  input  2  bank mode: 0 D, 1 T, 2 JK, 3 SR.
REQ-008 Port a  input  WIDTH  per-bit primary input (D / T / J / S).
REQ-009 Port b  input  WIDTH  per-bit secondary input (K / R); ignored in D and T modes.
REQ-010 Port err_clr  input  1  synchronous clear of sr_err (and err_cnt when enabled).
REQ-011 Port q  output  WIDTH  registered state.
REQ-012 Port qn  output  WIDTH  bitwise complement of q, derived combinationally.
REQ-013 Port sr_err  output  1  sticky flag: illegal SR combination seen.
REQ-014 Port err_cnt  output  CNT_W  illegal-SR cycle count; present only with UFF_ERR_CNT_EN.

Function
REQ-015 Update priority at each rising clk: rst > clr > en; with clr=1, q becomes 0 regardless of en/mode.
REQ-016 With en=0 and clr=0, q SHALL hold.
REQ-017 D mode: q[i] <= a[i].
REQ-018 T mode: q[i] <= q[i] ^ a[i].
REQ-019 JK mode per bit: 00 hold, 01 -> 0, 10 -> 1, 11 toggle.
REQ-020 SR mode per bit: 00 hold, 01 -> 0, 10 -> 1, 11 hold (deterministic; never X).
REQ-021 Latency: new q visible one cycle after the sampling edge; mode, a, b, en sampled at the same edge, no pipelining.
REQ-022 Mode changes take effect at the first edge they are sampled; no state is carried between modes except q.
REQ-023 Illegal SR event: en=1, clr=0, mode=SR and (a & b) != 0 on a sampled edge.
REQ-024 sr_err SHALL set on the edge following an illegal SR event and stay set until err_clr.
REQ-025 Simultaneous illegal SR event and err_clr: set wins, sr_err = 1.
REQ-026 An illegal event with clr=1 is not flagged (clr has priority, REQ-015).
REQ-027 Bits with legal combinations in the same cycle as an illegal bit update normally.

Reset
REQ-028 rst=1 SHALL immediately force q = 0, qn = all ones, sr_err = 0, err_cnt = 0, independent of clk.
REQ-029 Release of rst takes effect at the next rising clk; no update occurs on an edge where rst is still high.
REQ-030 rst asserted mid-toggle sequence discards all prior state; no partial update survives.

Configuration
REQ-031 Macro UFF_ERR_CNT_EN: when defined, err_cnt exists and increments by 1 per illegal SR event cycle (not per bit), saturating at 2^CNT_W-1.
REQ-032 err_clr with a simultaneous illegal event SHALL load err_cnt = 1.
REQ-033 Without UFF_ERR_CNT_EN, err_cnt port and counter logic are absent; all other behaviour is identical.

Structure
REQ-034 Package uff_pkg SHALL hold the mode typedef (MODE_D, MODE_T, MODE_JK, MODE_SR) and default parameter constants.
REQ-035 Sub-module uff_cell implements one bit (mode, a, b, q next-state plus per-bit illegal flag); the bank instantiates WIDTH copies via generate.

Verification
REQ-036 WIDTH=8, rst pulse mid-cycle -> q=0x00, qn=0xFF immediately, without waiting for clk.
REQ-037 JK mode, q=0x0F, a=0xFF, b=0xFF, en=1 for one edge -> q=0xF0; second edge -> q=0x0F.
REQ-038 SR mode, q=0x00, a=0x81, b=0x01 -> q=0x80, sr_err=1, err_cnt=1; repeat for 3 edges -> err_cnt=4.
REQ-039 T mode, en=0, a=0xFF for 5 edges -> q unchanged; clr=1 with en=1 -> q=0x00.
REQ-040 CNT_W=2, 5 consecutive illegal SR cycles -> err_cnt saturates at 3; err_clr with an illegal event -> err_cnt=1, sr_err=1.
REQ-041 D mode, a=0xA5, clr=1 and en=1 on the same edge -> q=0x00; next edge clr=0 -> q=0xA5.
